// File: rtl/pipe_control_if.sv
// Bundle of ID-stage inputs, hazard/mul-div handshake and staged control outputs
// exchanged between the decode datapath and pipe_control.
interface pipe_control_if #(
    parameter int OPCODE_W = 5,
    parameter int ALUOP_W  = 5,
    parameter int RADDR_W  = 5
);
    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [RADDR_W-1:0]  id_rs;
    logic [RADDR_W-1:0]  id_rt;
    logic [RADDR_W-1:0]  id_rd;
    logic                ex_branch_taken;
    logic                md_ready;
    logic                stall;
    logic                md_start;
    logic                ex_valid;
    logic                ex_ALUinB;
    logic                ex_RI;
    logic                ex_md;
    logic                mem_DMwe;
    logic                mem_lw;
    logic                wb_Rwe;
    logic                wb_lw;
    logic [RADDR_W-1:0]  wb_rd;

    modport master (
        output id_valid, id_opcode, id_aluop, id_rs, id_rt, id_rd,
        output ex_branch_taken, md_ready,
        input  stall, md_start, ex_valid, ex_ALUinB, ex_RI, ex_md,
        input  mem_DMwe, mem_lw, wb_Rwe, wb_lw, wb_rd
    );

    modport slave (
        input  id_valid, id_opcode, id_aluop, id_rs, id_rt, id_rd,
        input  ex_branch_taken, md_ready,
        output stall, md_start, ex_valid, ex_ALUinB, ex_RI, ex_md,
        output mem_DMwe, mem_lw, wb_Rwe, wb_lw, wb_rd
    );
endinterface

// File: rtl/pipe_control.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, load-use and
// mul/div stall sequencing, branch flush. Optional perf counters via CTRL_PERF_EN.
module pipe_control #(
    parameter int OPCODE_W   = 5,
    parameter int ALUOP_W    = 5,
    parameter int RADDR_W    = 5,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic          clock,
    input  logic          reset,
    pipe_control_if.slave bus
`ifdef CTRL_PERF_EN
    ,
    output logic [15:0]   perf_stall_cnt,
    output logic [15:0]   perf_flush_cnt,
    output logic [15:0]   perf_md_cnt
`endif
);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(5'b00000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(5'b00001);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5'b00010);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(5'b00011);
    localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(5'b00100);
    localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(5'b00110);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5'b00111);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(5'b01000);
    localparam logic [OPCODE_W-1:0] OP_SETX = OPCODE_W'(5'b10101);
    localparam logic [OPCODE_W-1:0] OP_BEX  = OPCODE_W'(5'b10110);
    localparam logic [ALUOP_W-1:0]  AOP_MUL = ALUOP_W'(5'b00110);
    localparam logic [ALUOP_W-1:0]  AOP_DIV = ALUOP_W'(5'b00111);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               alu_in_b;
        logic               ri;
        logic               md;
        logic               dmwe;
        logic               lw;
        logic               rwe;
        logic [RADDR_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic               dmwe;
        logic               lw;
        logic               rwe;
        logic [RADDR_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic               rwe;
        logic               lw;
        logic [RADDR_W-1:0] rd;
    } wb_ctrl_t;

    function automatic ex_ctrl_t decode_ctrl(
        input logic [OPCODE_W-1:0] op,
        input logic [ALUOP_W-1:0]  aluop,
        input logic [RADDR_W-1:0]  rd
    );
        ex_ctrl_t c;
        logic     no_wr;
        c          = '0;
        c.valid    = 1'b1;
        c.alu_in_b = (op != OP_R);
        c.ri       = (op != OP_R);
        c.dmwe     = (op == OP_SW);
        c.lw       = (op == OP_LW);
        c.md       = (op == OP_R) && ((aluop == AOP_MUL) || (aluop == AOP_DIV));
        case (op)
            OP_JAL:  c.rd = RADDR_W'(LINK_REG);
            OP_SETX: c.rd = RADDR_W'(STATUS_REG);
            default: c.rd = rd;
        endcase
        case (op)
            OP_SW, OP_J, OP_BNE, OP_JR, OP_BLT, OP_BEX: no_wr = 1'b1;
            default:                                    no_wr = 1'b0;
        endcase
        // r0 is hard zero, so a write to it is suppressed at decode time
        c.rwe = !no_wr && (c.rd != '0);
        return c;
    endfunction

    function automatic logic uses_rt(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_R, OP_SW, OP_BNE, OP_BLT: uses_rt = 1'b1;
            default:                     uses_rt = 1'b0;
        endcase
    endfunction

    ex_ctrl_t  ex_r;
    mem_ctrl_t mem_r;
    wb_ctrl_t  wb_r;
    logic [1:0] state_r;
    logic [1:0] state_next_s;
    ex_ctrl_t  id_ctrl_s;
    ex_ctrl_t  ex_next_s;
    logic      md_go_s;
    logic      md_hold_s;
    logic      load_use_s;
    logic      stall_s;

    // Decode, hazard detection and stall/flush arbitration (md stall beats flush beats load-use).
    always_comb begin
        id_ctrl_s  = decode_ctrl(bus.id_opcode, bus.id_aluop, bus.id_rd);
        md_go_s    = (state_r == ST_IDLE) && ex_r.valid && ex_r.md;
        md_hold_s  = md_go_s || (state_r == ST_BUSY);
        load_use_s = bus.id_valid && ex_r.lw && (ex_r.rd != '0) &&
                     ((ex_r.rd == bus.id_rs) ||
                      (uses_rt(bus.id_opcode) && (ex_r.rd == bus.id_rt)));
        if (reset) begin
            stall_s = 1'b0;
        end else if (md_hold_s) begin
            stall_s = 1'b1;
        end else if (bus.ex_branch_taken) begin
            stall_s = 1'b0;
        end else begin
            stall_s = load_use_s;
        end
        if (bus.ex_branch_taken || load_use_s || !bus.id_valid) begin
            ex_next_s = '0;
        end else begin
            ex_next_s = id_ctrl_s;
        end
    end

    // Mul/div handshake sequencing.
    always_comb begin
        case (state_r)
            ST_IDLE: state_next_s = md_go_s ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_next_s = bus.md_ready ? ST_DONE : ST_BUSY;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stage registers; all three freeze while a mul/div is starting or in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else if (md_hold_s) begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end else begin
            ex_r       <= ex_next_s;
            mem_r.dmwe <= ex_r.dmwe;
            mem_r.lw   <= ex_r.lw;
            mem_r.rwe  <= ex_r.rwe;
            mem_r.rd   <= ex_r.rd;
            wb_r.rwe   <= mem_r.rwe;
            wb_r.lw    <= mem_r.lw;
            wb_r.rd    <= mem_r.rd;
        end
    end

    // Bubbles are stored as all-zero bundles, so every field is already valid-gated.
    assign bus.stall     = stall_s;
    assign bus.md_start  = md_go_s && !reset;
    assign bus.ex_valid  = ex_r.valid;
    assign bus.ex_ALUinB = ex_r.alu_in_b;
    assign bus.ex_RI     = ex_r.ri;
    assign bus.ex_md     = ex_r.md;
    assign bus.mem_DMwe  = mem_r.dmwe;
    assign bus.mem_lw    = mem_r.lw;
    assign bus.wb_Rwe    = wb_r.rwe;
    assign bus.wb_lw     = wb_r.lw;
    assign bus.wb_rd     = wb_r.rd;

`ifdef CTRL_PERF_EN
    logic [15:0] perf_stall_cnt_r;
    logic [15:0] perf_flush_cnt_r;
    logic [15:0] perf_md_cnt_r;

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt_r <= 16'h0000;
            perf_flush_cnt_r <= 16'h0000;
            perf_md_cnt_r    <= 16'h0000;
        end else begin
            if (stall_s && (perf_stall_cnt_r != 16'hFFFF)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 16'h0001;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (bus.ex_branch_taken && (perf_flush_cnt_r != 16'hFFFF)) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + 16'h0001;
            end else begin
                perf_flush_cnt_r <= perf_flush_cnt_r;
            end
            if (md_go_s && (perf_md_cnt_r != 16'hFFFF)) begin
                perf_md_cnt_r <= perf_md_cnt_r + 16'h0001;
            end else begin
                perf_md_cnt_r <= perf_md_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
    assign perf_md_cnt    = perf_md_cnt_r;
`endif

endmodule
